// File: rtl/pet_pkg.sv
// Shared types and constants for the virtual pet status engine.
package pet_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        EATING   = 3'd1,
        PLAYING  = 3'd2,
        SLEEPING = 3'd3,
        DEAD     = 3'd4
    } pet_state_t;

    localparam int FACE_NEUTRAL  = 0;
    localparam int FACE_HAPPY    = 1;
    localparam int FACE_HUNGRY   = 2;
    localparam int FACE_SAD      = 3;
    localparam int FACE_TIRED    = 4;
    localparam int FACE_EATING   = 5;
    localparam int FACE_PLAYING  = 6;
    localparam int FACE_SLEEPING = 7;
    localparam int FACE_DEAD     = 8;

    localparam int FEED_GAIN = 2;
    localparam int JOY_GAIN  = 2;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Raw active-low button -> 2-FF synchroniser -> tick-based debouncer -> 1-clk press pulse.
module button_debouncer import pet_pkg::*; #(
    parameter int DEBOUNCE_TICKS = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic i_tick,
    input  logic i_btn_n,
    output logic o_press
);

    localparam int CW = cnt_w(DEBOUNCE_TICKS);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          r_press;

    // Accept a new level only after it has disagreed with the current one on
    // DEBOUNCE_TICKS consecutive ticks; any agreement restarts the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync1 <= i_btn_n;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (i_tick) begin
                if (r_cnt == CW'(DEBOUNCE_TICKS - 1)) begin
                    r_cnt   <= '0;
                    r_level <= r_sync2;
                    r_press <= ~r_sync2;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/pet_status_engine.sv
// Virtual pet state owner: buttons, timed actions, stat decay and face code.
module pet_status_engine import pet_pkg::*; #(
    parameter int MAX_VALUE        = 5,
    parameter int NUM_FACES        = 9,
    parameter int COUNT_MAX        = 800000,
    parameter int DEBOUNCE_TICKS   = 3,
    parameter int ACTION_TICKS     = 60,
    parameter int DECAY_TICKS      = 1875,
    parameter int SLEEP_STEP_TICKS = 250
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          btn_feed_n,
    input  logic                          btn_play_n,
    input  logic                          btn_sleep_n,
    output logic [$clog2(NUM_FACES)-1:0]  face,
    output logic [$clog2(MAX_VALUE):0]    feed_value,
    output logic [$clog2(MAX_VALUE):0]    joy_value,
    output logic [$clog2(MAX_VALUE):0]    energy_value
);

    localparam int SW  = $clog2(MAX_VALUE) + 1;
    localparam int FW  = $clog2(NUM_FACES);
    localparam int TW  = cnt_w(COUNT_MAX);
    localparam int ACW = cnt_w(ACTION_TICKS);
    localparam int DCW = cnt_w(DECAY_TICKS);
    localparam int SCW = cnt_w(SLEEP_STEP_TICKS);

    logic [TW-1:0]  r_tick_cnt;
    logic           w_tick;
    logic           w_press_feed, w_press_play, w_press_sleep;
    logic           w_sleep_only;

    pet_state_t     r_state, w_state_nxt;
    logic [SW-1:0]  r_feed, r_joy, r_energy;
    logic [SW-1:0]  w_feed_nxt, w_joy_nxt, w_energy_nxt;
    logic [ACW-1:0] r_action_cnt, w_action_nxt;
    logic [SCW-1:0] r_step_cnt, w_step_nxt;
    logic [DCW-1:0] r_decay_cnt, w_decay_nxt;
    logic           r_phase, w_phase_nxt;
    logic [FW-1:0]  r_face, w_face_nxt;

    // One spare bit on the way up so the saturation compare cannot wrap.
    logic [SW:0]    w_feed_up, w_joy_up, w_energy_inc;
    logic [SW-1:0]  w_feed_sat, w_joy_sat, w_energy_sat;
    logic [SW-1:0]  w_feed_dn, w_joy_dn, w_energy_dn;
    logic           w_all_zero;

    assign w_tick = (r_tick_cnt == TW'(COUNT_MAX - 1));

    // Free-running tick divider.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_tick_cnt <= '0;
        else        r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
    end

    button_debouncer #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_feed (
        .clk(clk), .reset(reset), .i_tick(w_tick), .i_btn_n(btn_feed_n),  .o_press(w_press_feed));
    button_debouncer #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_play (
        .clk(clk), .reset(reset), .i_tick(w_tick), .i_btn_n(btn_play_n),  .o_press(w_press_play));
    button_debouncer #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_sleep (
        .clk(clk), .reset(reset), .i_tick(w_tick), .i_btn_n(btn_sleep_n), .o_press(w_press_sleep));

    // A sleep press only counts when no higher-priority press shares its cycle.
    assign w_sleep_only = w_press_sleep & ~w_press_feed & ~w_press_play;

    assign w_feed_up    = {1'b0, r_feed}   + (SW+1)'(FEED_GAIN);
    assign w_joy_up     = {1'b0, r_joy}    + (SW+1)'(JOY_GAIN);
    assign w_energy_inc = {1'b0, r_energy} + 1'b1;
    assign w_feed_sat   = (w_feed_up    >= (SW+1)'(MAX_VALUE)) ? SW'(MAX_VALUE) : w_feed_up[SW-1:0];
    assign w_joy_sat    = (w_joy_up     >= (SW+1)'(MAX_VALUE)) ? SW'(MAX_VALUE) : w_joy_up[SW-1:0];
    assign w_energy_sat = (w_energy_inc >= (SW+1)'(MAX_VALUE)) ? SW'(MAX_VALUE) : w_energy_inc[SW-1:0];
    assign w_feed_dn    = (r_feed   == '0) ? '0 : r_feed   - 1'b1;
    assign w_joy_dn     = (r_joy    == '0) ? '0 : r_joy    - 1'b1;
    assign w_energy_dn  = (r_energy == '0) ? '0 : r_energy - 1'b1;
    assign w_all_zero   = (r_feed == '0) && (r_joy == '0) && (r_energy == '0);

    // State, stat and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_feed       <= SW'(MAX_VALUE);
            r_joy        <= SW'(MAX_VALUE);
            r_energy     <= SW'(MAX_VALUE);
            r_action_cnt <= '0;
            r_step_cnt   <= '0;
            r_decay_cnt  <= '0;
            r_phase      <= 1'b0;
            r_face       <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_feed       <= w_feed_nxt;
            r_joy        <= w_joy_nxt;
            r_energy     <= w_energy_nxt;
            r_action_cnt <= w_action_nxt;
            r_step_cnt   <= w_step_nxt;
            r_decay_cnt  <= w_decay_nxt;
            r_phase      <= w_phase_nxt;
            r_face       <= w_face_nxt;
        end
    end

    // Next-state and stat update; decay only runs while IDLE.
    always_comb begin
        w_state_nxt  = r_state;
        w_feed_nxt   = r_feed;
        w_joy_nxt    = r_joy;
        w_energy_nxt = r_energy;
        w_action_nxt = r_action_cnt;
        w_step_nxt   = r_step_cnt;
        w_decay_nxt  = r_decay_cnt;
        w_phase_nxt  = r_phase;
        case (r_state)
            IDLE: begin
                if (w_tick) begin
                    if (r_decay_cnt == DCW'(DECAY_TICKS - 1)) begin
                        w_decay_nxt = '0;
                        w_feed_nxt  = w_feed_dn;
                        w_joy_nxt   = w_joy_dn;
                        w_phase_nxt = ~r_phase;
                        if (r_phase) w_energy_nxt = w_energy_dn;
                    end else begin
                        w_decay_nxt = r_decay_cnt + 1'b1;
                    end
                end
                if (w_all_zero) begin
                    w_state_nxt = DEAD;
                end else if (w_press_feed) begin
                    w_state_nxt  = EATING;
                    w_action_nxt = '0;
                end else if (w_press_play) begin
                    if (r_energy != '0) begin
                        w_state_nxt  = PLAYING;
                        w_action_nxt = '0;
                    end
                end else if (w_press_sleep) begin
                    w_state_nxt = SLEEPING;
                    w_step_nxt  = '0;
                end
            end
            EATING, PLAYING: begin
                if (w_tick) begin
                    if (r_action_cnt == ACW'(ACTION_TICKS - 1)) begin
                        w_action_nxt = '0;
                        w_state_nxt  = IDLE;
                        if (r_state == EATING) begin
                            w_feed_nxt = w_feed_sat;
                        end else begin
                            w_joy_nxt    = w_joy_sat;
                            w_energy_nxt = w_energy_dn;
                        end
                    end else begin
                        w_action_nxt = r_action_cnt + 1'b1;
                    end
                end
            end
            SLEEPING: begin
                if (w_sleep_only) begin
                    w_state_nxt = IDLE;
                end else if (w_tick) begin
                    if (r_step_cnt == SCW'(SLEEP_STEP_TICKS - 1)) begin
                        w_step_nxt   = '0;
                        w_energy_nxt = w_energy_sat;
                        if (w_energy_inc >= (SW+1)'(MAX_VALUE)) w_state_nxt = IDLE;
                    end else begin
                        w_step_nxt = r_step_cnt + 1'b1;
                    end
                end
            end
            DEAD:    ;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Face selection from the current state and stats; first match wins.
    always_comb begin
        w_face_nxt = FW'(FACE_NEUTRAL);
        if (r_state == DEAD)                    w_face_nxt = FW'(FACE_DEAD);
        else if (r_state == SLEEPING)           w_face_nxt = FW'(FACE_SLEEPING);
        else if (r_state == PLAYING)            w_face_nxt = FW'(FACE_PLAYING);
        else if (r_state == EATING)             w_face_nxt = FW'(FACE_EATING);
        else if (r_feed   <= SW'(1))            w_face_nxt = FW'(FACE_HUNGRY);
        else if (r_energy <= SW'(1))            w_face_nxt = FW'(FACE_TIRED);
        else if (r_joy    <= SW'(1))            w_face_nxt = FW'(FACE_SAD);
        else if (r_feed   >= SW'(MAX_VALUE - 1) && r_joy >= SW'(MAX_VALUE - 1) &&
                 r_energy >= SW'(MAX_VALUE - 1)) w_face_nxt = FW'(FACE_HAPPY);
    end

    assign face         = r_face;
    assign feed_value   = r_feed;
    assign joy_value    = r_joy;
    assign energy_value = r_energy;

endmodule

// File: tb/tb_pet_status_engine.sv
// Bench for pet_status_engine: directed and random button activity checked
// tick by tick against a behavioural model of the pet.
module tb_pet_status_engine;

    localparam int MAXV = 5;
    localparam int CM   = 4;
    localparam int DB   = 2;
    localparam int AT   = 3;
    localparam int DT   = 5;
    localparam int ST   = 2;

    localparam int S_IDLE  = 10;
    localparam int S_EAT   = 11;
    localparam int S_PLAY  = 12;
    localparam int S_SLEEP = 13;
    localparam int S_DEAD  = 14;

    logic       clk = 1'b0;
    logic       reset;
    logic       bf, bp, bs;
    logic [3:0] face;
    logic [3:0] feed_value, joy_value, energy_value;

    int checks   = 0;
    int failures = 0;

    // model of the pet
    int m_st, m_feed, m_joy, m_energy;
    int m_dcnt, m_dsteps, m_acnt, m_scnt;
    int m_raw[3], m_prev[3], m_acc[3], m_run[3];

    logic [2:0] v;
    int         hold;

    always #5 clk = ~clk;

    pet_status_engine #(
        .MAX_VALUE(MAXV), .NUM_FACES(9), .COUNT_MAX(CM), .DEBOUNCE_TICKS(DB),
        .ACTION_TICKS(AT), .DECAY_TICKS(DT), .SLEEP_STEP_TICKS(ST)
    ) dut (
        .clk(clk), .reset(reset),
        .btn_feed_n(bf), .btn_play_n(bp), .btn_sleep_n(bs),
        .face(face), .feed_value(feed_value), .joy_value(joy_value),
        .energy_value(energy_value)
    );

    task automatic check(input string tag, input logic [7:0] obs, input int exp);
        checks++;
        assert (obs === 8'(exp))
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int up(input int x, input int g);
        return (x + g > MAXV) ? MAXV : x + g;
    endfunction

    function automatic int dn(input int x);
        return (x > 0) ? x - 1 : 0;
    endfunction

    function automatic int m_face();
        if (m_st == S_DEAD)  return 8;
        if (m_st == S_SLEEP) return 7;
        if (m_st == S_PLAY)  return 6;
        if (m_st == S_EAT)   return 5;
        if (m_feed <= 1)     return 2;
        if (m_energy <= 1)   return 4;
        if (m_joy <= 1)      return 3;
        if (m_feed >= MAXV-1 && m_joy >= MAXV-1 && m_energy >= MAXV-1) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_st = S_IDLE; m_feed = MAXV; m_joy = MAXV; m_energy = MAXV;
        m_dcnt = 0; m_dsteps = 0; m_acnt = 0; m_scnt = 0;
        for (int b = 0; b < 3; b++) begin
            m_raw[b] = 1; m_prev[b] = 1; m_acc[b] = 1; m_run[b] = 0;
        end
    endtask

    // One tick of pet life: timed effects, death, then any newly accepted press.
    // The level judged at a tick is the one driven during the previous tick
    // period, since the synchroniser has not yet passed the newest value.
    task automatic model_tick();
        bit pr[3];
        case (m_st)
            S_IDLE: begin
                m_dcnt++;
                if (m_dcnt == DT) begin
                    m_dcnt = 0; m_dsteps++;
                    m_feed = dn(m_feed); m_joy = dn(m_joy);
                    if (m_dsteps % 2 == 0) m_energy = dn(m_energy);
                end
            end
            S_EAT: begin
                m_acnt++;
                if (m_acnt == AT) begin m_feed = up(m_feed, 2); m_st = S_IDLE; end
            end
            S_PLAY: begin
                m_acnt++;
                if (m_acnt == AT) begin
                    m_joy = up(m_joy, 2); m_energy = dn(m_energy); m_st = S_IDLE;
                end
            end
            S_SLEEP: begin
                m_scnt++;
                if (m_scnt == ST) begin
                    m_scnt = 0; m_energy = up(m_energy, 1);
                    if (m_energy == MAXV) m_st = S_IDLE;
                end
            end
            default: ;
        endcase
        if (m_st == S_IDLE && m_feed == 0 && m_joy == 0 && m_energy == 0) m_st = S_DEAD;
        for (int b = 0; b < 3; b++) begin
            pr[b] = 1'b0;
            if (m_prev[b] != m_acc[b]) begin
                m_run[b]++;
                if (m_run[b] == DB) begin
                    m_acc[b] = m_prev[b]; m_run[b] = 0; pr[b] = (m_acc[b] == 0);
                end
            end else begin
                m_run[b] = 0;
            end
            m_prev[b] = m_raw[b];
        end
        if (pr[0]) begin
            if (m_st == S_IDLE) begin m_st = S_EAT; m_acnt = 0; end
        end else if (pr[1]) begin
            if (m_st == S_IDLE && m_energy >= 1) begin m_st = S_PLAY; m_acnt = 0; end
        end else if (pr[2]) begin
            if (m_st == S_IDLE) begin m_st = S_SLEEP; m_scnt = 0; end
            else if (m_st == S_SLEEP) m_st = S_IDLE;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".feed"},   8'(feed_value),   m_feed);
        check({tag, ".joy"},    8'(joy_value),    m_joy);
        check({tag, ".energy"}, 8'(energy_value), m_energy);
        check({tag, ".face"},   8'(face),         m_face());
    endtask

    // Called at the settled point just before a tick edge; drives the buttons,
    // lets one tick period elapse and compares with the model.
    task automatic step(input string tag, input logic f, input logic p, input logic s);
        bf = f; bp = p; bs = s;
        m_raw[0] = int'(f); m_raw[1] = int'(p); m_raw[2] = int'(s);
        repeat (CM) @(posedge clk);
        #1;
        model_tick();
        check_all(tag);
    endtask

    task automatic press(input string tag, input logic f, input logic p, input logic s, input int n);
        repeat (n) step(tag, f, p, s);
        repeat (3) step(tag, 1'b1, 1'b1, 1'b1);
    endtask

    initial begin
        reset = 1'b0; bf = 1'b1; bp = 1'b1; bs = 1'b1;
        model_reset();
        #22;
        check("rst.feed",   8'(feed_value),   5);
        check("rst.joy",    8'(joy_value),    5);
        check("rst.energy", 8'(energy_value), 5);
        check("rst.face",   8'(face),         0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rel.face0", 8'(face), 0);
        @(posedge clk); #1;
        check("rel.face1", 8'(face), 1);
        repeat (2) @(posedge clk); #1;

        repeat (5) step("idle", 1'b1, 1'b1, 1'b1);
        check("decay5.feed",   8'(feed_value),   4);
        check("decay5.joy",    8'(joy_value),    4);
        check("decay5.energy", 8'(energy_value), 5);
        repeat (5) step("idle", 1'b1, 1'b1, 1'b1);
        check("decay10.feed",   8'(feed_value),   3);
        check("decay10.energy", 8'(energy_value), 4);
        check("decay10.face",   8'(face),         0);

        // held feed: a single meal
        press("feedhold", 1'b0, 1'b1, 1'b1, 20);
        // drain energy through play, including presses with no energy left
        repeat (6) press("play", 1'b1, 1'b0, 1'b1, 2);
        press("sleep", 1'b1, 1'b1, 1'b0, 2);
        repeat (10) step("slp", 1'b1, 1'b1, 1'b1);
        press("sleep2", 1'b1, 1'b1, 1'b0, 2);
        press("sleepx", 1'b1, 1'b1, 1'b0, 2);
        press("both", 1'b0, 1'b0, 1'b1, 2);
        repeat (4) step("both", 1'b1, 1'b1, 1'b1);

        for (int i = 0; i < 70; i++) begin
            v    = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) v = 3'b111;
            hold = $urandom_range(1, 5);
            repeat (hold) step("rand", v[0], v[1], v[2]);
        end

        repeat (130) step("starve", 1'b1, 1'b1, 1'b1);
        check("starve.face", 8'(face), 8);
        for (int i = 0; i < 8; i++) begin
            v = 3'($urandom_range(0, 7));
            repeat (3) step("dead", v[0], v[1], v[2]);
        end

        // reset mid-cycle while dead
        bf = 1'b1; bp = 1'b1; bs = 1'b1;
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        check("midrst.feed",   8'(feed_value),   5);
        check("midrst.joy",    8'(joy_value),    5);
        check("midrst.energy", 8'(energy_value), 5);
        check("midrst.face",   8'(face),         0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk); #1;
        model_reset();

        // start a meal, then abort it with reset
        repeat (3) step("abort", 1'b0, 1'b1, 1'b1);
        check("abort.face", 8'(face), 5);
        bf = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        check("abort.feed", 8'(feed_value), 5);
        check("abort.rface", 8'(face), 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk); #1;
        model_reset();
        repeat (4) step("post", 1'b1, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pet_status_engine.md
Name: pet_status_engine

Overview:
Upstream producer of the LCD status stage: owns the virtual pet's state and emits face, feed_value, joy_value and energy_value, which feed the LCD1602 controller directly.
Handles three raw push-buttons (feed, play, sleep), a timed action state machine and periodic stat decay.
All timing is derived from an internal tick of COUNT_MAX clock cycles (16 ms at 50 MHz).

Parameters:
MAX_VALUE, 5, saturation ceiling of each stat.
NUM_FACES, 9, number of face codes.
COUNT_MAX, 800000, clk cycles per tick.
DEBOUNCE_TICKS, 3, ticks a button level must be stable before it is accepted.
ACTION_TICKS, 60, duration of EATING and PLAYING in ticks.
DECAY_TICKS, 1875, IDLE ticks per decay step.
SLEEP_STEP_TICKS, 250, ticks per energy increment while SLEEPING.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-low reset.
btn_feed_n  in  1  raw feed button, active-low, asynchronous.
btn_play_n  in  1  raw play button, active-low, asynchronous.
btn_sleep_n  in  1  raw sleep button, active-low, asynchronous.
face  out  $clog2(NUM_FACES)  face code, registered.
feed_value  out  $clog2(MAX_VALUE)+1  hunger stat, 0..MAX_VALUE.
joy_value  out  $clog2(MAX_VALUE)+1  happiness stat.
energy_value  out  $clog2(MAX_VALUE)+1  energy stat.

Behaviour:
- Reset (reset=0, async): all stats = MAX_VALUE, face = 0, state = IDLE. Tick, decay and action counters = 0. Synchronisers = 1.
- Tick: tick_cnt counts 0..COUNT_MAX-1. A one-cycle tick pulse is issued on wrap.
- Button path, per button:
  - 2-FF synchroniser, then debouncer. Debounced level changes only after the synced level differs from it on DEBOUNCE_TICKS consecutive ticks.
  - A 1-clk press pulse is issued on the debounced 1->0 edge.
  - Holding a button yields exactly one press.
- Simultaneous presses in the same cycle: priority feed > play > sleep. Lower-priority presses are dropped.
- FSM states: IDLE, EATING, PLAYING, SLEEPING, DEAD.
- IDLE:
  - feed press -> EATING, action_cnt = 0.
  - play press -> PLAYING only if energy_value >= 1; otherwise ignored.
  - sleep press -> SLEEPING, step_cnt = 0.
  - Each tick advances decay_cnt. On reaching DECAY_TICKS: decay_cnt = 0; feed_value and joy_value decrement, saturating at 0.
  - energy_value decrements on every second decay step (1-bit phase flag), saturating at 0.
- EATING: counts ACTION_TICKS ticks, then feed_value += 2 (saturate at MAX_VALUE) and return to IDLE on the same cycle. Presses are ignored.
- PLAYING: counts ACTION_TICKS ticks, then joy_value += 2 (saturate) and energy_value -= 1 (saturate at 0), then IDLE. Presses are ignored.
- SLEEPING:
  - Every SLEEP_STEP_TICKS ticks, energy_value += 1.
  - Reaching MAX_VALUE -> IDLE.
  - A sleep press -> IDLE immediately. Feed and play presses are ignored.
- Decay counter holds its value (neither advances nor clears) outside IDLE.
- DEAD: entered from IDLE when feed_value, joy_value and energy_value are all 0. Absorbing; only reset exits.
- Stat arithmetic uses one extra internal bit before the saturation compare. Outputs never exceed MAX_VALUE and never underflow.
- Face code, registered one cycle after the state/stat change. First match wins:
  - DEAD = 8
  - SLEEPING = 7
  - PLAYING = 6
  - EATING = 5
  - feed_value <= 1 -> 2 (hungry)
  - energy_value <= 1 -> 4 (tired)
  - joy_value <= 1 -> 3 (sad)
  - all stats >= MAX_VALUE-1 -> 1 (happy)
  - otherwise 0 (neutral)
- After reset release, face reads 0 for one cycle, then 1.
- Reset asserted mid-action aborts the action with no stat update.

Decomposition:
- Package pet_pkg holds:
  - state enum: IDLE=0, EATING=1, PLAYING=2, SLEEPING=3, DEAD=4
  - face constants FACE_NEUTRAL..FACE_DEAD = 0..8
  - stat increment constants FEED_GAIN=2, JOY_GAIN=2
- Sub-module button_debouncer (synchroniser + debounce + press pulse), instantiated three times and sharing the tick pulse.

Test Plan:
Bench parameters for all scenarios: COUNT_MAX=4, DEBOUNCE_TICKS=2, ACTION_TICKS=3, DECAY_TICKS=5, SLEEP_STEP_TICKS=2.
- Reset then idle 2 clk -> stats 5/5/5; face 0 then 1. After 5 ticks: feed=4, joy=4, energy=5. After 10 ticks: 3/3/4, face 0.
- Drive feed=1, joy=3, energy=3, then press feed held 20 ticks -> one EATING, face 5. After 3 ticks feed=3, face 0, state IDLE.
- Energy=0, press play -> stays IDLE, face 4, no stat change. Energy=2, press play -> face 6. After 3 ticks: joy +2 saturating at 5, energy=1.
- Press feed and play in the same cycle -> EATING only; joy unchanged.
- Energy=2, press sleep -> face 7, energy 3,4,5 every 2 ticks, then IDLE. Second run: a sleep press after 2 ticks exits with energy=3.
- Let decay run to 0/0/0 -> face 8; all presses ignored. Assert reset asynchronously mid-cycle -> outputs 5/5/5 and face 0 immediately.
